integration_result_sink: RTL
============================

Name: integration_result_sink

Overview:
- Downstream stage of the integrator. Consumes the integrator's N-bit running result `coe_R` on a valid qualifier.
- Decimates the sample stream by a programmable ratio and buffers the kept samples in a show-ahead FIFO.
- Presents them on a ready/valid streaming source to the readout logic.
- Flags samples dropped on FIFO overflow.

Parameters:
- N, 32, data width; equal to the integrator width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DW, 8, width of the decimation-ratio input.

Ports:
- csi_clk  in  1  system clock; all logic on rising edge.
- rsi_srst  in  1  synchronous, active-high reset.
- asi_data  in  N  integrator result (`coe_R` of the upstream stage).
- asi_valid  in  1  asi_data holds a new sample this cycle.
- coe_decim  in  DW  decimation ratio; keep 1 of every coe_decim valid samples; 0 is treated as 1.
- aso_data  out  N  head-of-FIFO sample.
- aso_valid  out  1  FIFO non-empty.
- aso_ready  in  1  consumer accepts aso_data this cycle.
- coe_ovf  out  1  sticky overflow flag.
- coe_ovf_clr  in  1  clears coe_ovf.
- coe_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rsi_srst=1 at a clock edge):
  - Clears wr_ptr, rd_ptr, count, the decimation counter dcnt and coe_ovf.
  - Outputs after reset: aso_valid=0, coe_level=0, coe_ovf=0. aso_data is don't-care (memory is not cleared).
  - Reset overrides every other input in that cycle, including mid-burst; all buffered data is discarded.
- Decimation:
  - dcnt (DW bits) advances only on asi_valid=1.
  - eff = max(coe_decim, 1).
  - On asi_valid: if dcnt >= eff-1, the sample is "kept" and dcnt<=0; else dcnt<=dcnt+1.
  - The >= compare makes a mid-count decrease of coe_decim keep the next valid sample.
  - With eff=1, every valid sample is kept.
- Push:
  - push = kept AND (count<DEPTH OR pop).
  - A kept sample arriving when count==DEPTH and pop=0 is dropped and sets coe_ovf=1.
- Pop: pop = aso_valid AND aso_ready.
- FIFO:
  - Show-ahead: aso_data = mem[rd_ptr], aso_valid = (count!=0).
  - A sample pushed at edge k is visible on aso_data/aso_valid after edge k; latency from asi_valid to aso_valid is 1 cycle.
  - Pointers wrap modulo DEPTH.
  - count updates: +1 on push only, -1 on pop only, unchanged on both.
  - Simultaneous push and pop when full: both happen, count stays DEPTH, no overflow.
  - Simultaneous push and pop when empty: not possible (pop requires aso_valid); no bypass.
- Overflow flag:
  - Set has priority over coe_ovf_clr in the same cycle.
  - coe_ovf_clr alone clears it on the next edge.
- Registered outputs: aso_valid and coe_level follow the registered count.
- Consumer rules:
  - aso_ready is ignored while aso_valid=0.
  - aso_data is held stable while aso_valid=1 and aso_ready=0.
- Data path: no arithmetic on data; samples pass bit-exact.

Optional Feature:
- Macro: INTEGRATION_SINK_DROP_CNT_EN.
- Defined:
  - Adds output coe_drop_cnt (16 bits), counting dropped samples.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by coe_ovf_clr. A drop in the same cycle as coe_ovf_clr gives a count of 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle with asi_valid=0:
  - Expect aso_valid=0, coe_level=0, coe_ovf=0.
- Pass-through:
  - Stimulus: coe_decim=1, aso_ready=1, asi_data=5,10,15 on consecutive valid cycles.
  - Expect aso_data=5,10,15 each one cycle later, coe_level never above 1.
- Decimation:
  - Stimulus: coe_decim=3, aso_ready=1, asi_data=1..9 valid.
  - Expect output 3,6,9 only.
  - Repeat with coe_decim=0; expect all 9 samples.
- Fill and overflow:
  - Stimulus: DEPTH=8, coe_decim=1, aso_ready=0, push 10 samples 100..109.
  - Expect coe_level=8 and coe_ovf=1.
  - Drain; expect 100..107 in order, then aso_valid=0.
  - With the macro defined, coe_drop_cnt=2.
- Full with simultaneous push/pop:
  - Stimulus: fill to 8, then one cycle with asi_valid=1 and aso_ready=1.
  - Expect coe_level stays 8, coe_ovf stays 0, head advances.
- Reset mid-operation:
  - Stimulus: coe_level=5, assert rsi_srst for one cycle.
  - Expect coe_level=0 and aso_valid=0 next cycle; dcnt restarts, so with coe_decim=3 the 3rd subsequent valid sample is the first kept.

Source files
------------

// File: rtl/integration_result_sink_if.sv
// Streaming bundle for the integration result sink.
// Input side (asi_*) carries integrator results and has no back-pressure.
// Output side (aso_*) is a ready/valid source toward the readout logic.
// N must match the N parameter of the integration_result_sink that uses it.
interface integration_result_sink_if #(
  parameter int N = 32
);
  logic [N-1:0] asi_data;
  logic         asi_valid;
  logic [N-1:0] aso_data;
  logic         aso_valid;
  logic         aso_ready;

  // Producer/consumer side: drives samples in and readiness, observes the stream out
  modport master (
    output asi_data,
    output asi_valid,
    output aso_ready,
    input  aso_data,
    input  aso_valid
  );

  // Sink side: consumes integrator samples and sources the buffered stream
  modport slave (
    input  asi_data,
    input  asi_valid,
    input  aso_ready,
    output aso_data,
    output aso_valid
  );
endinterface

// File: rtl/integration_result_sink.sv
// Integration result sink.
// Decimates the integrator result stream by coe_decim (0 behaves as 1), buffers
// kept samples in a show-ahead FIFO and presents them on a ready/valid source.
// A kept sample that finds the FIFO full (with no pop that cycle) is dropped and
// sets the sticky coe_ovf flag.
// Optional feature macro: INTEGRATION_SINK_DROP_CNT_EN adds a saturating 16-bit
// dropped-sample counter on output coe_drop_cnt.
module integration_result_sink #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                       csi_clk,
  input  logic                       rsi_srst,
  integration_result_sink_if.slave   bus,
  input  logic [DW-1:0]              coe_decim,
  output logic                       coe_ovf,
  input  logic                       coe_ovf_clr,
`ifdef INTEGRATION_SINK_DROP_CNT_EN
  output logic [15:0]                coe_drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]     coe_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Sample storage; show-ahead read so the head is always on aso_data
  logic [N-1:0]  mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] count_reg, count_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic          ovf_reg, ovf_next;

  logic [DW-1:0] eff;
  logic [DW-1:0] eff_m1;
  logic          kept;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;

  // Decimation decision and FIFO handshake qualifiers
  always_comb begin
    eff    = (coe_decim == '0) ? DW'(1) : coe_decim;
    eff_m1 = eff - DW'(1);
    // >= (not ==) so lowering the ratio mid-count keeps the very next sample
    kept   = bus.asi_valid && (dcnt_reg >= eff_m1);
    full   = (count_reg == LW'(DEPTH));
    pop    = (count_reg != '0) && bus.aso_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    push   = kept && (!full || pop);
    drop   = kept && !push;
  end

  // Next-state for pointers, occupancy, decimation counter and overflow flag
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    dcnt_next   = dcnt_reg;
    ovf_next    = ovf_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    if (push && !pop) begin
      count_next = count_reg + LW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - LW'(1);
    end

    if (bus.asi_valid) begin
      dcnt_next = kept ? '0 : dcnt_reg + DW'(1);
    end

    // A new drop wins over a clear request in the same cycle
    if (drop) begin
      ovf_next = 1'b1;
    end else if (coe_ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dcnt_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      dcnt_reg   <= dcnt_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Sample memory write; contents are never cleared, only the pointers are
  always_ff @(posedge csi_clk) begin
    if (push && !rsi_srst) begin
      mem[wr_ptr_reg] <= bus.asi_data;
    end
  end

`ifdef INTEGRATION_SINK_DROP_CNT_EN
  logic [15:0] drop_cnt_reg, drop_cnt_next;

  // Saturating drop counter; a drop coinciding with a clear restarts at 1
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (coe_ovf_clr) begin
      drop_cnt_next = drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_next = drop_cnt_reg + 16'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      drop_cnt_reg <= '0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign coe_drop_cnt = drop_cnt_reg;
`endif

  // Outputs are all derived from registered state
  assign bus.aso_data  = mem[rd_ptr_reg];
  assign bus.aso_valid = (count_reg != '0);
  assign coe_level     = count_reg;
  assign coe_ovf       = ovf_reg;

endmodule
